// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared width, iteration count and state encoding for the divider
package divider_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = WIDTH;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/divider_div_step.sv
// rtl/divider_div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int W = divider_pkg::WIDTH
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // The partial remainder stays below the divisor magnitude (at most 2^(W-1)),
    // so the shifted value fits in W+1 bits and diff[W] is a true sign bit.
    always_comb begin
        shifted = {rem_i, quo_i[W-1]};
        diff    = shifted - {1'b0, dvs_i};
        if (!diff[W]) begin
            rem_o = diff[W-1:0];
            quo_o = {quo_i[W-2:0], 1'b1};
        end else begin
            rem_o = shifted[W-1:0];
            quo_o = {quo_i[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - multi-cycle signed restoring divider, one quotient bit per clock
module divider #(
    parameter int WIDTH = divider_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             exception
);

    import divider_pkg::*;

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             exc_q, exc_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] step_rem, step_quo;

    div_step #(.W(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        out_d     = out_q;
        rout_d    = rout_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        exc_d     = exc_q;
        // The finishing operation still reports even if a new start arrives in DONE.
        ready_d   = (state_q == DONE);

        if (start) begin
            state_d   = RUN;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = dividend[WIDTH-1] ? -dividend : dividend;
            dvs_d     = divisor[WIDTH-1] ? -divisor : divisor;
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
            zero_d    = (divisor == '0);
            ovf_d     = (dividend == MIN_VAL) && (divisor == '1);
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        exc_d   = zero_q | ovf_q;
                        if (zero_q) begin
                            out_d  = '0;
                            rout_d = '0;
                        end else if (ovf_q) begin
                            out_d  = MIN_VAL;
                            rout_d = '0;
                        end else begin
                            out_d  = neg_quo_q ? -step_quo : step_quo;
                            rout_d = neg_rem_q ? -step_rem : step_rem;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            out_q     <= '0;
            rout_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            exc_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            out_q     <= out_d;
            rout_q    <= rout_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            exc_q     <= exc_d;
            ready_q   <= ready_d;
        end
    end

    assign out       = out_q;
    assign remainder = rout_q;
    assign exception = exc_q;
    assign ready     = ready_q;

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width.
REQ-002 clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  single-cycle request to begin a division; operands are sampled on the same edge.
REQ-005 dividend  input  WIDTH  signed two's-complement numerator.
REQ-006 divisor  input  WIDTH  signed two's-complement denominator.
REQ-007 out  output  WIDTH  signed quotient, truncated toward zero.
REQ-008 remainder  output  WIDTH  signed remainder; its sign matches the dividend.
REQ-009 ready  output  1  one-cycle pulse; out, remainder and exception are valid when it is high.
REQ-010 exception  output  1  set for divide-by-zero or overflow; valid with ready.

Function
REQ-011 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-012 IDLE to RUN occurs on an edge with start=1; that edge SHALL latch |dividend|, |divisor|, both operand signs and the zero/overflow flags, and clear the iteration counter.
REQ-013 RUN SHALL perform one restoring iteration per edge: shift the {partial remainder, quotient} pair left by 1, trial-subtract |divisor|, keep the result if it is non-negative and set the quotient LSB to 1, otherwise restore and set it to 0.
REQ-014 RUN SHALL last exactly WIDTH edges; after the WIDTH-th iteration the state goes to DONE.
REQ-015 Latency: if start is sampled at edge N, ready SHALL be high for the single cycle following edge N+WIDTH+1 (edge N+33 for WIDTH=32); DONE then goes to IDLE.
REQ-016 Sign fix-up at DONE entry: the quotient is negated when the operand signs differ, and the remainder is negated when the dividend is negative.
REQ-017 When divisor=0: exception=1, out=0, remainder=0, with the same latency as a normal division.
REQ-018 When dividend=0x80000000 and divisor=0xFFFFFFFF: exception=1, out=0x80000000, remainder=0, with the same latency.
REQ-019 In every other case exception=0.
REQ-020 out, remainder and exception SHALL hold their values after ready falls, until the next DONE or reset.
REQ-021 start=1 during RUN SHALL abort the current operation, reload the operands and restart the count; no ready pulse is issued for the aborted operation.
REQ-022 start=1 during DONE SHALL be accepted: ready still pulses for the finishing operation, and the state goes to RUN.
REQ-023 Operand inputs are ignored except on an edge where start is accepted.
REQ-024 The magnitude of 0x80000000 SHALL be handled as unsigned 2^31, which needs no extra width.

Reset
REQ-025 On a clk edge with rst=1: state=IDLE, counter=0, internal registers=0, out=0, remainder=0, ready=0, exception=0.
REQ-026 rst SHALL take priority over start on the same edge.
REQ-027 rst during RUN or DONE SHALL discard the operation, and no ready pulse is issued for it.

Structure
REQ-028 A shared package SHALL hold WIDTH, the iteration count (WIDTH), the counter width (6 bits) and the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
REQ-029 One sub-module, div_step, SHALL be a purely combinational single iteration: inputs are the partial remainder, the quotient and the divisor magnitude; outputs are the next partial remainder and the next quotient.
REQ-030 All sequential state SHALL live in divider: the FSM, the counter, the operand and result registers, and the sign and exception flags.
REQ-031 Every register SHALL use synchronous reset only.

Verification
REQ-032 Case 1: start with 100 / 7 -> ready exactly 33 edges later; out=14, remainder=2, exception=0.
REQ-033 Case 2: start with -100 / 7 -> out=-14 (0xFFFFFFF2), remainder=-2. Start with 100 / -7 -> out=-14, remainder=2.
REQ-034 Case 3: start with 12345 / 0 -> ready at 33 edges; exception=1, out=0, remainder=0.
REQ-035 Case 4: start with 0x80000000 / 0xFFFFFFFF -> exception=1, out=0x80000000. Start with 0x80000000 / 1 -> out=0x80000000, exception=0.
REQ-036 Case 5: start with 50 / 5, then start again 10 edges later with 81 / 9 -> exactly one ready pulse, 33 edges after the second start, with out=9.
REQ-037 Case 6: rst asserted mid-RUN -> no ready pulse and all outputs 0. A following start with 7 / 2 gives out=3, remainder=1.
